// File: rtl/cpu_project_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_project_pkg
//  Description : Shared widths, data types and ALU opcode constants for the
//                single-bus datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_project_pkg;

   localparam int c_word_w  = 32;
   localparam int c_dword_w = 64;
   localparam int c_op_w    = 5;

   typedef logic [c_word_w-1:0]  word_t;
   typedef logic [c_dword_w-1:0] dword_t;
   typedef logic [c_op_w-1:0]    opcode_t;

   localparam opcode_t c_op_add = 5'b00011;
   localparam opcode_t c_op_sub = 5'b00100;
   localparam opcode_t c_op_shr = 5'b00101;
   localparam opcode_t c_op_shl = 5'b00110;
   localparam opcode_t c_op_ror = 5'b00111;
   localparam opcode_t c_op_rol = 5'b01000;
   localparam opcode_t c_op_and = 5'b01001;
   localparam opcode_t c_op_or  = 5'b01010;
   localparam opcode_t c_op_mul = 5'b01110;
   localparam opcode_t c_op_div = 5'b01111;
   localparam opcode_t c_op_neg = 5'b10000;
   localparam opcode_t c_op_not = 5'b10001;

endpackage
`default_nettype wire

// File: rtl/cpu_project_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_project_if
//  Description : Operand/opcode/result bundle between the datapath and the
//                ALU. The datapath is the master (drives operands), the ALU
//                is the slave (returns the 64-bit result).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_project_if;
   import cpu_project_pkg::*;

   word_t   a;
   word_t   b;
   opcode_t op;
   dword_t  result;

   modport master (output a, output b, output op, input result);
   modport slave  (input a, input b, input op, output result);

endinterface
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_alu
//  Description : Purely combinational ALU. A comes from Y, B from the bus.
//                Only mul and div produce a non-zero upper half; unknown
//                opcodes and divide-by-zero yield an all-zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
   import cpu_project_pkg::*;
(
   cpu_project_if.slave alu
);

   logic [5:0] w_sh;
   logic [5:0] w_sh_inv;
   word_t      w_rol;
   word_t      w_ror;
   dword_t     w_prod;
   word_t      w_quot;
   word_t      w_rem;
   dword_t     w_result;

   // Shifts/rotates use only B[4:0]; a zero amount leaves the operand intact
   // because a shift by the full word width yields zero.
   assign w_sh     = {1'b0, alu.b[4:0]};
   assign w_sh_inv = 6'd32 - w_sh;
   assign w_rol    = (alu.a << w_sh) | (alu.a >> w_sh_inv);
   assign w_ror    = (alu.a >> w_sh) | (alu.a << w_sh_inv);

   // Signed multiply done at full 64-bit width on sign-extended operands.
   assign w_prod = $signed({{32{alu.a[31]}}, alu.a}) * $signed({{32{alu.b[31]}}, alu.b});

   // Signed divide; a zero divisor forces both quotient and remainder to 0.
   always_comb begin
      w_quot = '0;
      w_rem  = '0;
      if (alu.b != '0) begin
         w_quot = $signed(alu.a) / $signed(alu.b);
         w_rem  = $signed(alu.a) % $signed(alu.b);
      end
   end

   // Opcode decode into the 64-bit result.
   always_comb begin
      w_result = '0;
      case (alu.op)
         c_op_add: w_result[31:0] = alu.a + alu.b;
         c_op_sub: w_result[31:0] = alu.a - alu.b;
         c_op_shr: w_result[31:0] = alu.a >> w_sh;
         c_op_shl: w_result[31:0] = alu.a << w_sh;
         c_op_ror: w_result[31:0] = w_ror;
         c_op_rol: w_result[31:0] = w_rol;
         c_op_and: w_result[31:0] = alu.a & alu.b;
         c_op_or:  w_result[31:0] = alu.a | alu.b;
         c_op_mul: w_result       = w_prod;
         c_op_div: w_result       = {w_rem, w_quot};
         c_op_neg: w_result[31:0] = '0 - alu.b;
         c_op_not: w_result[31:0] = ~alu.b;
         default:  w_result       = '0;
      endcase
   end

   assign alu.result = w_result;

endmodule
`default_nettype wire

// File: rtl/cpu_project.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_project
//  Description : Single-bus datapath: register file, PC, IR, MAR, MDR, Y,
//                HI, LO, C and 64-bit Z around a prioritised internal bus
//                and the cpu_alu sub-module. All state changes on Clock's
//                rising edge; Clear is a synchronous reset that wins over
//                every load and increment enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_project
   import cpu_project_pkg::*;
(
   input  wire logic    PCout,
   input  wire logic    ZHighout,
   input  wire logic    Zlowout,
   input  wire logic    MDRout,
   input  wire logic    R2out,
   input  wire logic    R4out,
   input  wire logic    MARin,
   input  wire logic    PCin,
   input  wire logic    MDRin,
   input  wire logic    IRin,
   input  wire logic    Yin,
   input  wire logic    IncPC,
   input  wire logic    Read,
   input  wire opcode_t ROL,
   input  wire logic    R5in,
   input  wire logic    R2in,
   input  wire logic    R4in,
   input  wire logic    Clock,
   input  wire word_t   Mdatain,
   input  wire logic    Clear,
   input  wire logic    R1in,
   input  wire logic    R3in,
   input  wire logic    R6in,
   input  wire logic    R7in,
   input  wire logic    R8in,
   input  wire logic    R9in,
   input  wire logic    R10in,
   input  wire logic    R11in,
   input  wire logic    R12in,
   input  wire logic    R13in,
   input  wire logic    R14in,
   input  wire logic    R15in,
   input  wire logic    HIin,
   input  wire logic    LOin,
   input  wire logic    ZHighIn,
   input  wire logic    ZLowIn,
   input  wire logic    Cin,
   output word_t        BusMuxOut
);

   // R0 is hardwired to zero and is never a bus source, so only R1..R15
   // need storage.
   word_t       r_gpr [1:15];
   word_t       r_pc;
   word_t       r_ir;
   word_t       r_mar;
   word_t       r_mdr;
   word_t       r_y;
   word_t       r_hi;
   word_t       r_lo;
   word_t       r_c;
   dword_t      r_z;

   word_t       w_bus;
   word_t       w_mdr_in;
   logic [15:1] w_rin;
   logic        w_unused_regs;

   cpu_project_if alu_bus ();

   assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};

   // Fixed-priority bus source select; idle bus reads as zero.
   always_comb begin
      w_bus = '0;
      if (PCout)         w_bus = r_pc;
      else if (MDRout)   w_bus = r_mdr;
      else if (ZHighout) w_bus = r_z[63:32];
      else if (Zlowout)  w_bus = r_z[31:0];
      else if (R2out)    w_bus = r_gpr[2];
      else if (R4out)    w_bus = r_gpr[4];
   end

   assign BusMuxOut = w_bus;
   assign w_mdr_in  = Read ? Mdatain : w_bus;

   assign alu_bus.a  = r_y;
   assign alu_bus.b  = w_bus;
   assign alu_bus.op = ROL;

   cpu_alu u_alu (
      .alu (alu_bus)
   );

   // All register loads; each captures the pre-edge bus, so a register may
   // drive the bus and reload in the same cycle.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         for (int i = 1; i < 16; i++) r_gpr[i] <= '0;
         r_pc  <= '0;
         r_ir  <= '0;
         r_mar <= '0;
         r_mdr <= '0;
         r_y   <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_c   <= '0;
         r_z   <= '0;
      end else begin
         for (int i = 1; i < 16; i++) begin
            if (w_rin[i]) r_gpr[i] <= w_bus;
         end
         if (PCin)         r_pc <= w_bus;
         else if (IncPC)   r_pc <= r_pc + 32'd1;
         if (IRin)  r_ir  <= w_bus;
         if (MARin) r_mar <= w_bus;
         if (MDRin) r_mdr <= w_mdr_in;
         if (Yin)   r_y   <= w_bus;
         if (HIin)  r_hi  <= w_bus;
         if (LOin)  r_lo  <= w_bus;
         if (Cin)   r_c   <= w_bus;
         if (ZHighIn) r_z[63:32] <= alu_bus.result[63:32];
         if (ZLowIn)  r_z[31:0]  <= alu_bus.result[31:0];
      end
   end

   // IR, MAR, HI, LO and C have no bus path yet; they are kept for the
   // control unit and memory interface that will consume them.
   assign w_unused_regs = ^{r_ir, r_mar, r_hi, r_lo, r_c};

endmodule
`default_nettype wire

// File: tb/tb_cpu_project.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_project
//  Description : Directed self-checking bench for cpu_project plus a direct
//                probe of cpu_alu through its interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_project;
   import cpu_project_pkg::*;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
   logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
   logic [4:0]  ROL;
   logic [31:0] Mdatain;
   logic [15:1] rin;
   logic [31:0] BusMuxOut;

   int checks = 0;
   int errors = 0;

   cpu_project dut (
      .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .R2out(R2out), .R4out(R4out), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .ROL(ROL),
      .R5in(rin[5]), .R2in(rin[2]), .R4in(rin[4]), .Clock(Clock),
      .Mdatain(Mdatain), .Clear(Clear), .R1in(rin[1]), .R3in(rin[3]),
      .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]),
      .R10in(rin[10]), .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]),
      .R14in(rin[14]), .R15in(rin[15]), .HIin(HIin), .LOin(LOin),
      .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin), .BusMuxOut(BusMuxOut)
   );

   cpu_project_if alu_tb ();
   cpu_alu u_alu_probe (.alu(alu_tb));

   always #5 Clock = ~Clock;

   // Single comparison point for every check in the bench.
   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Clear = 0; PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; R2out = 0;
      R4out = 0; MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0;
      Read = 0; HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
      ROL = 5'b0; rin = '0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic mdr_load(input logic [31:0] v);
      idle();
      Mdatain = v; Read = 1; MDRin = 1;
      tick();
      idle();
   endtask

   task automatic alu_vec(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
      alu_tb.op = op; alu_tb.a = a; alu_tb.b = b;
      #1;
      check_value(tag, alu_tb.result, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      Mdatain = '0;
      alu_tb.op = '0; alu_tb.a = '0; alu_tb.b = '0;

      // reset state
      Clear = 1; tick(); tick(); idle();
      #1;
      check_value("rst_bus", BusMuxOut, 0);
      check_value("rst_pc", dut.r_pc, 0);
      check_value("rst_z", dut.r_z, 0);
      check_value("rst_mdr", dut.r_mdr, 0);

      // R2/R4/R5 load and rol scenario
      mdr_load(32'h8000_0000); MDRout = 1; rin[2] = 1; tick(); idle();
      mdr_load(32'h0000_0002); MDRout = 1; rin[4] = 1; tick(); idle();
      mdr_load(32'h0000_0027); MDRout = 1; rin[5] = 1; tick(); idle();
      check_value("r2_load", dut.r_gpr[2], 32'h8000_0000);
      check_value("r4_load", dut.r_gpr[4], 32'h0000_0002);
      check_value("r5_load", dut.r_gpr[5], 32'h0000_0027);
      R2out = 1; Yin = 1; tick(); idle();
      check_value("y_from_r2", dut.r_y, 32'h8000_0000);
      R4out = 1; ROL = 5'b01000; ZLowIn = 1; #1;
      check_value("bus_r4", BusMuxOut, 32'h2);
      tick(); idle();
      check_value("z_rol", dut.r_z, 64'h0000_0000_0000_0002);
      Zlowout = 1; rin[5] = 1; tick(); idle();
      check_value("r5_rol", dut.r_gpr[5], 32'h2);

      // bus priority (MDR=0x27, PC=0, Z={0,2}, R2=0x80000000, R4=2)
      MDRout = 1; R2out = 1; #1; check_value("pri_mdr_r2", BusMuxOut, 32'h27); idle();
      PCout = 1; MDRout = 1; #1; check_value("pri_pc_mdr", BusMuxOut, 32'h0); idle();
      ZHighout = 1; Zlowout = 1; #1; check_value("pri_zh_zl", BusMuxOut, 32'h0); idle();
      Zlowout = 1; R2out = 1; #1; check_value("pri_zl_r2", BusMuxOut, 32'h2); idle();
      R2out = 1; R4out = 1; #1; check_value("pri_r2_r4", BusMuxOut, 32'h8000_0000); idle();
      R4out = 1; #1; check_value("bus_r4_only", BusMuxOut, 32'h2); idle();

      // same-cycle drive and load of one register
      R2out = 1; rin[2] = 1; tick(); idle();
      check_value("r2_self", dut.r_gpr[2], 32'h8000_0000);

      // PC / MAR / increment
      mdr_load(32'd7); MDRout = 1; PCin = 1; tick(); idle();
      check_value("pc_load", dut.r_pc, 32'd7);
      PCout = 1; MARin = 1; IncPC = 1; tick(); idle();
      check_value("mar_pc", dut.r_mar, 32'd7);
      check_value("pc_inc", dut.r_pc, 32'd8);
      MDRout = 1; PCin = 1; IncPC = 1; tick(); idle();
      check_value("pc_prio", dut.r_pc, 32'd7);
      mdr_load(32'hFFFF_FFFF); MDRout = 1; PCin = 1; tick(); idle();
      IncPC = 1; tick(); idle();
      check_value("pc_wrap", dut.r_pc, 32'd0);

      // mul into both Z halves, then independent half loads
      mdr_load(32'hFFFF_FFFE); MDRout = 1; Yin = 1; tick(); idle();
      mdr_load(32'd3); MDRout = 1; ROL = 5'b01110; ZHighIn = 1; ZLowIn = 1; tick(); idle();
      check_value("z_mul", dut.r_z, 64'hFFFF_FFFF_FFFF_FFFA);
      MDRout = 1; ROL = 5'b00011; ZLowIn = 1; tick(); idle();
      check_value("z_lo_only", dut.r_z, 64'hFFFF_FFFF_0000_0001);
      MDRout = 1; ROL = 5'b00100; ZHighIn = 1; tick(); idle();
      check_value("z_hi_only", dut.r_z, 64'h0000_0000_0000_0001);

      // div by zero through the datapath (idle bus = 0)
      mdr_load(32'd7); MDRout = 1; Yin = 1; tick(); idle();
      ROL = 5'b01111; ZHighIn = 1; ZLowIn = 1; tick(); idle();
      check_value("z_div0", dut.r_z, 64'h0);

      // load everything, then Clear with all enables still asserted
      mdr_load(32'hA5A5_A5A5);
      MDRout = 1; rin = '1; MARin = 1; IRin = 1; Yin = 1; HIin = 1; LOin = 1;
      Cin = 1; PCin = 1; tick(); idle();
      check_value("pre_hi", dut.r_hi, 32'hA5A5_A5A5);
      MDRout = 1; ROL = 5'b00011; ZLowIn = 1; tick(); idle();
      check_value("pre_z", dut.r_z, 64'h0000_0000_4B4B_4B4A);
      Clear = 1; MDRout = 1; rin = '1; MARin = 1; IRin = 1; Yin = 1; HIin = 1;
      LOin = 1; Cin = 1; PCin = 1; IncPC = 1; Read = 1; MDRin = 1;
      Mdatain = 32'h1234_5678; ROL = 5'b00011; ZHighIn = 1; ZLowIn = 1;
      tick(); idle(); #1;
      for (int i = 1; i < 16; i++) check_value($sformatf("clr_r%0d", i), dut.r_gpr[i], 0);
      check_value("clr_pc", dut.r_pc, 0);
      check_value("clr_ir", dut.r_ir, 0);
      check_value("clr_mar", dut.r_mar, 0);
      check_value("clr_mdr", dut.r_mdr, 0);
      check_value("clr_y", dut.r_y, 0);
      check_value("clr_hi", dut.r_hi, 0);
      check_value("clr_lo", dut.r_lo, 0);
      check_value("clr_c", dut.r_c, 0);
      check_value("clr_z", dut.r_z, 0);
      check_value("clr_bus", BusMuxOut, 0);

      // direct ALU vectors
      alu_vec("alu_add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'h1, 64'h0);
      alu_vec("alu_sub", 5'b00100, 32'h1, 32'h2, 64'h0000_0000_FFFF_FFFF);
      alu_vec("alu_shr", 5'b00101, 32'h8000_0000, 32'hFFFF_FFFF, 64'h1);
      alu_vec("alu_shl", 5'b00110, 32'h1, 32'h24, 64'h10);
      alu_vec("alu_ror", 5'b00111, 32'h1, 32'h1, 64'h8000_0000);
      alu_vec("alu_rol0", 5'b01000, 32'h8000_0001, 32'h0, 64'h8000_0001);
      alu_vec("alu_rol", 5'b01000, 32'h8000_0001, 32'h4, 64'h18);
      alu_vec("alu_and", 5'b01001, 32'hF0F0, 32'hFF00, 64'hF000);
      alu_vec("alu_or", 5'b01010, 32'hF0F0, 32'hFF00, 64'hFFF0);
      alu_vec("alu_mul", 5'b01110, 32'h7FFF_FFFF, 32'h2, 64'h0000_0000_FFFF_FFFE);
      alu_vec("alu_div", 5'b01111, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
      alu_vec("alu_div0", 5'b01111, 32'h5, 32'h0, 64'h0);
      alu_vec("alu_neg", 5'b10000, 32'h0, 32'h1, 64'h0000_0000_FFFF_FFFF);
      alu_vec("alu_not", 5'b10001, 32'h0, 32'h0, 64'h0000_0000_FFFF_FFFF);
      alu_vec("alu_op0", 5'b00000, 32'h5, 32'h5, 64'h0);
      alu_vec("alu_op31", 5'b11111, 32'h5, 32'h5, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
